// File: rtl/hazard_unit_if.sv
// Decode-side inputs and EX-side forwarding/stall/flush controls of the hazard unit.
// The hazard unit attaches through the slave modport; the pipeline attaches through master.
interface hazard_unit_if;
  logic       validD;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       useRsD;
  logic       useRtD;
  logic [4:0] writeRegD;
  logic       regWriteD;
  logic       memToRegD;
  logic       JR_branch_signal;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;

  modport master (
    output validD, rsD, rtD, useRsD, useRtD, writeRegD, regWriteD, memToRegD,
           JR_branch_signal,
    input  ForwardA, ForwardB, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  validD, rsD, rtD, useRsD, useRtD, writeRegD, regWriteD, memToRegD,
           JR_branch_signal,
    output ForwardA, ForwardB, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the five-stage MIPS pipeline: shadows the
// destination of each in-flight instruction, forwards, stalls on load-use, flushes on redirect.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  hazard_unit_if.slave     hz,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  slot_t slot_e, slot_m, slot_w;
  slot_t entry_d;
  logic  lu;
  logic  load_entry;
  logic  [1:0] fwd_a_next, fwd_b_next;

  function automatic logic hit(input slot_t s, input logic [4:0] r);
    return s.valid && s.we && (s.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input slot_t e, input slot_t m);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && hit(e, r) && !e.ld) sel = 2'b10;
    else if (use_r && hit(m, r))      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    entry_d    = '{valid: hz.validD,
                   we:    hz.regWriteD & hz.validD,
                   rd:    hz.writeRegD,
                   ld:    hz.memToRegD & hz.validD};
    lu         = hz.validD &&
                 ((hz.useRsD && hit(slot_e, hz.rsD) && slot_e.ld) ||
                  (hz.useRtD && hit(slot_e, hz.rtD) && slot_e.ld));
    hz.StallF  = 1'b0;
    hz.StallD  = 1'b0;
    hz.FlushD  = 1'b0;
    hz.FlushE  = 1'b0;
    load_entry = 1'b1;
    // A redirect squashes the decode slot, so any pending load-use is moot.
    if (hz.JR_branch_signal) begin
      hz.FlushD  = 1'b1;
      hz.FlushE  = 1'b1;
      load_entry = 1'b0;
    end else if (lu) begin
      hz.StallF  = 1'b1;
      hz.StallD  = 1'b1;
      hz.FlushE  = 1'b1;
      load_entry = 1'b0;
    end
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (load_entry && hz.validD) begin
      fwd_a_next = fwd_sel(hz.useRsD, hz.rsD, slot_e, slot_m);
      fwd_b_next = fwd_sel(hz.useRtD, hz.rtD, slot_e, slot_m);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_e      <= '0;
      slot_m      <= '0;
      slot_w      <= '0;
      hz.ForwardA <= 2'b00;
      hz.ForwardB <= 2'b00;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      slot_w      <= slot_m;
      slot_m      <= slot_e;
      slot_e      <= load_entry ? entry_d : '0;
      hz.ForwardA <= fwd_a_next;
      hz.ForwardB <= fwd_b_next;
      if (lu && !hz.JR_branch_signal && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (hz.JR_branch_signal && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  // W is tracked for completeness of the shadow pipe but never forwarded from:
  // the register file is write-before-read.
  logic unused_w;
  assign unused_w = ^slot_w;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector and randomized check of hazard_unit against a queue-based model
// of the in-flight instructions.
module tb_hazard_unit;
  localparam int CNT_W = 6;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic CLOCK;
  logic RESET_N;
  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_unit_if hif ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .hz          (hif),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] wr;
    logic       rw, mem, jr;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } rec_t;

  // q[0] is the youngest in-flight instruction (in EX), q[1] the one after it (in MEM).
  rec_t q[$];
  int   exp_stall, exp_flush;
  int   total, bad;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    b = '{valid: 1'b0, we: 1'b0, rd: 5'd0, ld: 1'b0};
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(b);
    exp_stall = 0;
    exp_flush = 0;
  endtask

  function automatic logic writes(input int d, input logic [4:0] r);
    return (r != 5'd0) && q[d].valid && q[d].we && (q[d].rd == r);
  endfunction

  // Nearest producer in EX or MEM; a load in EX never gets here because it stalls.
  function automatic logic [1:0] nearest(input logic valid, input logic use_r,
                                         input logic [4:0] r);
    if (!valid || !use_r) return 2'b00;
    for (int d = 0; d < 2; d++)
      if (writes(d, r)) return (d == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic run_cycle(input vec_t v, input bit tab);
    logic lu, est, efd, efe;
    logic [1:0] efa, efb;
    rec_t ent;
    hif.validD = v.v;  hif.rsD = v.rs;  hif.rtD = v.rt;
    hif.useRsD = v.urs; hif.useRtD = v.urt; hif.writeRegD = v.wr;
    hif.regWriteD = v.rw; hif.memToRegD = v.mem; hif.JR_branch_signal = v.jr;
    @(negedge CLOCK);
    lu  = v.v && q[0].ld && ((v.urs && writes(0, v.rs)) || (v.urt && writes(0, v.rt)));
    est = !v.jr && lu;
    efd = v.jr;
    efe = v.jr || lu;
    efa = efe ? 2'b00 : nearest(v.v, v.urs, v.rs);
    efb = efe ? 2'b00 : nearest(v.v, v.urt, v.rt);
    if (tab) begin
      est = v.st; efd = v.fd; efe = v.fe; efa = v.fa; efb = v.fb;
    end
    chk("StallF", int'(hif.StallF), int'(est));
    chk("StallD", int'(hif.StallD), int'(est));
    chk("FlushD", int'(hif.FlushD), int'(efd));
    chk("FlushE", int'(hif.FlushE), int'(efe));
    if (v.jr) begin
      if (exp_flush < SAT) exp_flush++;
    end else if (lu) begin
      if (exp_stall < SAT) exp_stall++;
    end
    @(posedge CLOCK);
    #1;
    if (efe) ent = '{valid: 1'b0, we: 1'b0, rd: 5'd0, ld: 1'b0};
    else     ent = '{valid: v.v, we: v.rw & v.v, rd: v.wr, ld: v.mem & v.v};
    q.push_front(ent);
    void'(q.pop_back());
    chk("ForwardA", int'(hif.ForwardA), int'(efa));
    chk("ForwardB", int'(hif.ForwardB), int'(efb));
    chk("stall_count", int'(stall_count), exp_stall);
    chk("flush_count", int'(flush_count), exp_flush);
  endtask

  task automatic drive_idle();
    hif.validD = 0; hif.rsD = 0; hif.rtD = 0; hif.useRsD = 0; hif.useRtD = 0;
    hif.writeRegD = 0; hif.regWriteD = 0; hif.memToRegD = 0; hif.JR_branch_signal = 0;
  endtask

  vec_t tab[$];
  vec_t rv;

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    RESET_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_ForwardA", int'(hif.ForwardA), 0);
    chk("rst_ForwardB", int'(hif.ForwardB), 0);
    chk("rst_StallF", int'(hif.StallF), 0);
    chk("rst_FlushE", int'(hif.FlushE), 0);
    chk("rst_stall_count", int'(stall_count), 0);
    chk("rst_flush_count", int'(flush_count), 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;

    //          v  rs rt urs urt wr rw mem jr  st fd fe  fa     fb
    tab.push_back('{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // add $3
    tab.push_back('{1, 3, 4, 1, 1, 6, 1, 0, 0,  0, 0, 0, 2'b10, 2'b00}); // sub $6,$3,$4
    tab.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // nop
    tab.push_back('{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // add $3
    tab.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // nop
    tab.push_back('{1, 3, 3, 1, 1, 4, 1, 0, 0,  0, 0, 0, 2'b01, 2'b01}); // or $4,$3,$3
    tab.push_back('{1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // add $3
    tab.push_back('{1, 3, 0, 1, 0, 3, 1, 0, 0,  0, 0, 0, 2'b10, 2'b00}); // addi $3,$3
    tab.push_back('{1, 3, 3, 1, 1, 7, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10}); // nearest wins
    tab.push_back('{1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00}); // lw $5
    tab.push_back('{1, 2, 5, 1, 1, 8, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00}); // load-use stall
    tab.push_back('{1, 2, 5, 1, 1, 8, 1, 0, 0,  0, 0, 0, 2'b00, 2'b01}); // replay
    tab.push_back('{1, 1, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // addi $0
    tab.push_back('{1, 0, 0, 1, 1, 9, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // reads $0
    tab.push_back('{1, 1, 0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00}); // lw $0
    tab.push_back('{1, 0, 0, 1, 1, 9, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // no $0 stall
    tab.push_back('{1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00}); // lw $5
    tab.push_back('{1, 5, 5, 1, 1, 8, 1, 0, 1,  0, 1, 1, 2'b00, 2'b00}); // redirect + lu
    tab.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 2'b00, 2'b00}); // redirect
    tab.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 2'b00, 2'b00}); // back-to-back
    tab.push_back('{1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 2'b00, 2'b00}); // lw $5
    tab.push_back('{0, 5, 5, 1, 1, 8, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00}); // invalid reader
    tab.push_back('{1, 5, 0, 1, 0, 8, 1, 0, 0,  0, 0, 0, 2'b01, 2'b00}); // lw now in M
    foreach (tab[i]) run_cycle(tab[i], 1'b1);
    chk("tab_stall_count", int'(stall_count), 1);
    chk("tab_flush_count", int'(flush_count), 3);

    // Reset asserted while a load-use stall is being driven.
    run_cycle('{1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00}, 1'b0);
    hif.validD = 1; hif.rsD = 5; hif.rtD = 0; hif.useRsD = 1; hif.useRtD = 0;
    hif.writeRegD = 8; hif.regWriteD = 1; hif.memToRegD = 0; hif.JR_branch_signal = 0;
    @(negedge CLOCK);
    chk("pre_rst_StallF", int'(hif.StallF), 1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_StallF", int'(hif.StallF), 0);
    chk("mid_rst_StallD", int'(hif.StallD), 0);
    chk("mid_rst_FlushE", int'(hif.FlushE), 0);
    chk("mid_rst_ForwardA", int'(hif.ForwardA), 0);
    chk("mid_rst_ForwardB", int'(hif.ForwardB), 0);
    chk("mid_rst_stall_count", int'(stall_count), 0);
    chk("mid_rst_flush_count", int'(flush_count), 0);
    model_reset();
    @(posedge CLOCK);
    drive_idle();
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;

    // lw $5,0($5) repeatedly: every other cycle is a load-use stall.
    for (int i = 0; i < 2 * (SAT + 1 + 3) + 1; i++)
      run_cycle('{1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00}, 1'b0);
    chk("stall_saturated", int'(stall_count), SAT);

    for (int i = 0; i < 400; i++) begin
      rv.v   = ($urandom_range(0, 9) != 0);
      rv.rs  = 5'($urandom_range(0, 3));
      rv.rt  = 5'($urandom_range(0, 3));
      rv.urs = 1'($urandom_range(0, 1));
      rv.urt = 1'($urandom_range(0, 1));
      rv.wr  = 5'($urandom_range(0, 3));
      rv.rw  = ($urandom_range(0, 3) != 0);
      rv.mem = ($urandom_range(0, 2) == 0);
      rv.jr  = ($urandom_range(0, 7) == 0);
      rv.st = 0; rv.fd = 0; rv.fe = 0; rv.fa = 0; rv.fb = 0;
      run_cycle(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
